// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - 32-bit iterative multiply/divide unit with HI/LO result registers
// One shift-add or restoring shift-subtract step per cycle; results land after 32 RUN cycles.
module mul_div_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        hi_we,
   input  logic        lo_we,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic        div_q, div_d;
   logic        sa_q, sa_d;
   logic        sb_q, sb_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [63:0] p_q, p_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        done_q, done_d;

   logic [32:0] mul_sum;
   logic [63:0] mul_step;
   logic [32:0] div_shift;
   logic [32:0] div_diff;
   logic [63:0] div_step;
   logic [63:0] step;
   logic [63:0] prod;
   logic [31:0] res_hi;
   logic [31:0] res_lo;

   // p holds {partial product, multiplier} or {remainder, dividend/quotient}
   always_comb begin
      mul_sum   = {1'b0, p_q[63:32]} + {1'b0, b_q};
      mul_step  = p_q[0] ? {mul_sum, p_q[31:1]} : {1'b0, p_q[63:32], p_q[31:1]};
      div_shift = {p_q[63:32], p_q[31]};
      div_diff  = div_shift - {1'b0, b_q};
      div_step  = div_diff[32] ? {div_shift[31:0], p_q[30:0], 1'b0}
                               : {div_diff[31:0], p_q[30:0], 1'b1};
      step      = div_q ? div_step : mul_step;
   end

   // Sign flags are only ever set for signed ops, so unsigned ops pass through untouched
   always_comb begin
      prod   = step;
      res_hi = step[63:32];
      res_lo = step[31:0];
      if (!div_q) begin
         if (sa_q ^ sb_q) prod = 64'd0 - step;
         res_hi = prod[63:32];
         res_lo = prod[31:0];
      end else if (b_q == 32'd0) begin
         res_hi = a_q;
         res_lo = 32'hFFFF_FFFF;
      end else begin
         if (sa_q ^ sb_q) res_lo = 32'd0 - step[31:0];
         if (sa_q)        res_hi = 32'd0 - step[63:32];
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      a_d     = a_q;
      b_d     = b_q;
      p_d     = p_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               cnt_d   = 6'd0;
               div_d   = op[1];
               sa_d    = op[0] & A[31];
               sb_d    = op[0] & B[31];
               a_d     = A;
               b_d     = (op[0] & B[31]) ? 32'd0 - B : B;
               p_d     = {32'd0, (op[0] & A[31]) ? 32'd0 - A : A};
            end else begin
               if (hi_we) hi_d = wdata;
               if (lo_we) lo_d = wdata;
            end
         end
         RUN: begin
            p_d   = step;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
               state_d = IDLE;
               hi_d    = res_hi;
               lo_d    = res_lo;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 6'd0;
         div_q   <= 1'b0;
         sa_q    <= 1'b0;
         sb_q    <= 1'b0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         p_q     <= 64'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         a_q     <= a_d;
         b_q     <= b_d;
         p_q     <= p_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q == RUN);
   assign done = done_q;
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule
